conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Producer side of the 5x5 convolution datapath.
- Accepts a raster-scan pixel stream with a valid/ready handshake.
- Buffers four previous image lines plus a 5x5 shift window.
- For every valid 5x5 neighbourhood, presents the 25 pixels in parallel, in the element order the conv MAC/adder-tree unit consumes. One window per accepted pixel once the window is fully populated.

Parameters:
- DATA_WIDTH, 12, pixel width in bits (signed; passed through unmodified).
- FILTER_WIDTH, 5, window edge. Fixed at 5; any other value is unsupported.
- INPUT_WIDTH, 32, pixels per image line.
- INPUT_HEIGTH, 32, lines per frame.
- OUTPUT_WIDTH, INPUT_WIDTH-FILTER_WIDTH+1 (28), windows per output row.
- OUTPUT_HEIGTH, INPUT_HEIGTH-FILTER_WIDTH+1 (28), output rows per frame.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block can accept a pixel this cycle
- in_pixel  in  DATA_WIDTH  signed pixel, raster order (row-major, col 0 first)
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  consumer accepts the window this cycle
- win_data  out  25*DATA_WIDTH  element k=i*5+j (i = row offset, j = col offset from top-left) at bits [k*DATA_WIDTH +: DATA_WIDTH]
- win_row  out  clog2(OUTPUT_HEIGTH)  output row of the window (top-left row)
- win_col  out  clog2(OUTPUT_WIDTH)  output column of the window (top-left col)
- frame_done  out  1  asserted together with the frame's last window (row 27, col 27)

Behaviour:
- Reset (rst_n low, asynchronous) clears every output to 0: in_ready=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0.
  - Also clears the row/col counters, window registers and state.
  - Line-buffer contents need not be cleared.
  - in_ready rises on the first clk edge after reset release.
- Handshake:
  - A pixel is accepted when in_valid && in_ready.
  - in_ready = !(win_valid && !win_ready), i.e. the block stalls only while an unaccepted window is pending.
  - While a window is pending and not accepted, win_data, win_row, win_col and frame_done hold stable.
- Counters:
  - col counts 0..INPUT_WIDTH-1 per accepted pixel.
  - On wrap, col returns to 0 and row increments 0..INPUT_HEIGTH-1.
  - After (INPUT_HEIGTH-1, INPUT_WIDTH-1), both return to 0. The next frame starts immediately, with no bubble.
- Line buffers:
  - 4 lines of INPUT_WIDTH entries, chained.
  - On accept, each column slot shifts old line 3→discard, 2→3, 1→2, 0→1, new pixel→0.
  - The 5x5 window shifts left by one column. The new right column is {line3, line2, line1, line0, in_pixel} at the current col, top to bottom.
- States:
  - IDLE: after reset, no pixel yet. Goes to FILL on the first accept.
  - FILL: row<4. No windows are emitted. Goes to STREAM at the first accept with row==4.
  - STREAM: row>=4. Goes to FILL when row/col wrap to (0,0).
  - No explicit DONE state; frame_done is a flag.
- Window emission:
  - Accepting pixel (r,c) with r>=4 and c>=4 registers a window. win_valid goes high on the next clk edge (latency 1).
  - That window has win_row=r-4, win_col=c-4, and element k = pixel(r-4+k/5, c-4+k%5).
  - Pixels with c<4 only update the window/line state. Windows never straddle a line wrap.
- win_valid clearing and refill:
  - win_valid clears on win_ready unless a new window is registered the same cycle.
  - Simultaneous win_ready and emitting accept: the new window replaces the old one, win_valid stays 1, with no gap.
- Frames:
  - frame_done=1 only with the window (27,27). It clears on that window's acceptance.
  - Each frame emits exactly OUTPUT_WIDTH*OUTPUT_HEIGTH = 784 windows.
- Data: pure pass-through, no arithmetic. Signed values are carried bit-exact.
- Reset mid-frame:
  - All counters and flags clear; any pending window is dropped.
  - The next accepted pixel is treated as (0,0). Stale line data is never emitted, because row<4 suppresses windows.

Test Plan:
- Ramp frame with pixel=(r*32+c) mod 2048, win_ready=1, in_valid=1 continuously → first window appears one cycle after pixel (4,4) is accepted, win_row=0, win_col=0, element k = (k/5)*32 + k%5. Exactly 784 windows; the last has win_row=27, win_col=27, frame_done=1, element 24 = 31*32+31.
- Random win_ready low periods during the ramp frame → in_ready=0 whenever win_valid&&!win_ready. Window contents and order are identical to the no-stall run, with no drops or duplicates.
- Random in_valid gaps → window values and coordinates unchanged. win_valid pulses only after accepts at c>=4, r>=4.
- Two back-to-back frames, the second with pixel = -(r*32+c) → second frame's window (0,0) element 0 = 0, element 6 = -33. Sign bits are intact, with no contamination from frame 1.
- rst_n low mid-frame at pixel (10,17), then a fresh ramp frame → all outputs 0 during reset. The fresh frame produces the same 784 windows as the first scenario.
- Output window (5,9) reached → element 12 equals pixel (7,11), confirming the k=i*5+j packing.

Source files
------------

// File: rtl/conv_window_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_window_gen : raster pixel stream -> parallel 5x5 windows (4 line buffers)
// Revision 1.0
// ---------------------------------------------------------------------------
module conv_window_gen #(
  parameter int DATA_WIDTH    = 12,
  parameter int FILTER_WIDTH  = 5,
  parameter int INPUT_WIDTH   = 32,
  parameter int INPUT_HEIGTH  = 32,
  parameter int OUTPUT_WIDTH  = INPUT_WIDTH - FILTER_WIDTH + 1,
  parameter int OUTPUT_HEIGTH = INPUT_HEIGTH - FILTER_WIDTH + 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic signed [DATA_WIDTH-1:0]                    in_pixel,
  output logic                                            win_valid,
  input  logic                                            win_ready,
  output logic [FILTER_WIDTH*FILTER_WIDTH*DATA_WIDTH-1:0] win_data,
  output logic [$clog2(OUTPUT_HEIGTH)-1:0]                win_row,
  output logic [$clog2(OUTPUT_WIDTH)-1:0]                 win_col,
  output logic                                            frame_done
);

  localparam int c_col_w  = $clog2(INPUT_WIDTH);
  localparam int c_row_w  = $clog2(INPUT_HEIGTH);
  localparam int c_ocol_w = $clog2(OUTPUT_WIDTH);
  localparam int c_orow_w = $clog2(OUTPUT_HEIGTH);
  localparam int c_taps   = FILTER_WIDTH * FILTER_WIDTH;
  localparam int c_lines  = FILTER_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_started;
  logic [c_row_w-1:0]    r_row;
  logic [c_col_w-1:0]    r_col;
  logic                  r_win_valid;
  logic [c_orow_w-1:0]   r_win_row;
  logic [c_ocol_w-1:0]   r_win_col;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_line [c_lines][INPUT_WIDTH];
  logic [DATA_WIDTH-1:0] r_win  [FILTER_WIDTH][FILTER_WIDTH];

  logic w_accept;
  logic w_emit;
  logic w_col_last;
  logic w_row_last;
  logic w_frame_last;

  assign in_ready     = r_started && !(r_win_valid && !win_ready);
  assign w_accept     = in_valid && in_ready;
  assign w_col_last   = (r_col == c_col_w'(INPUT_WIDTH - 1));
  assign w_row_last   = (r_row == c_row_w'(INPUT_HEIGTH - 1));
  assign w_frame_last = w_col_last && w_row_last;

  assign win_valid  = r_win_valid;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Windows only leave in STREAM, so stale line data after a reset is never seen.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (w_accept && (r_row == c_row_w'(FILTER_WIDTH - 1))) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_emit = w_accept && (r_col >= c_col_w'(FILTER_WIDTH - 1));
        if (w_accept && w_frame_last) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line[0][r_col] <= in_pixel;
      for (int l = 1; l < c_lines; l++) begin
        r_line[l][r_col] <= r_line[l-1][r_col];
      end
    end
  end

  // Oldest line feeds the top row of the incoming window column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FILTER_WIDTH; i++) begin
        for (int j = 0; j < FILTER_WIDTH; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < FILTER_WIDTH; i++) begin
        for (int j = 0; j < FILTER_WIDTH - 1; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
      end
      for (int i = 0; i < c_lines; i++) begin
        r_win[i][FILTER_WIDTH-1] <= r_line[c_lines-1-i][r_col];
      end
      r_win[FILTER_WIDTH-1][FILTER_WIDTH-1] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
    end else if (w_emit) begin
      r_win_valid  <= 1'b1;
      r_win_row    <= c_orow_w'(r_row - c_row_w'(FILTER_WIDTH - 1));
      r_win_col    <= c_ocol_w'(r_col - c_col_w'(FILTER_WIDTH - 1));
      r_frame_done <= w_frame_last;
    end else if (win_ready) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  for (genvar k = 0; k < c_taps; k++) begin : g_pack
    assign win_data[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k/FILTER_WIDTH][k%FILTER_WIDTH];
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// tb_conv_window_gen : randomized handshake bench with an image-array reference model.
module tb_conv_window_gen;

  localparam int DW = 12;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int NT = 25;
  localparam int XW = NT * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          win_ready = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic          in_ready;
  logic          win_valid;
  logic [XW-1:0] win_data;
  logic [4:0]    win_row;
  logic [4:0]    win_col;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [XW-1:0] data;
    int            row;
    int            col;
    logic          fd;
    int            m;
  } win_t;

  win_t          q[$];
  logic [DW-1:0] img [H][W];
  int            mr, mc, acc_cnt, win_cnt, mode;
  int            total = 0;
  int            bad = 0;
  bit            pend, up;

  function automatic logic [DW-1:0] pix(int r, int c);
    int v;
    v = r * W + c;
    if (mode == 1) return DW'(-v);
    return DW'(v % 2048);
  endfunction

  task automatic chk(string tag, logic [XW-1:0] got, logic [XW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(bit v, bit rdy);
    logic [DW-1:0] px;
    bit            acc, cons;
    win_t          e;
    px = pix(mr, mc);
    in_valid = v; in_pixel = px; win_ready = rdy;
    #1;
    chk("in_ready", XW'(in_ready), XW'(up && !(pend && !rdy)));
    chk("win_valid", XW'(win_valid), XW'(pend));
    acc  = in_valid && in_ready;
    cons = win_valid && win_ready;
    if (cons) begin
      chk("win_expected", XW'(q.size() > 0), XW'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        win_cnt++;
        chk("win_data", win_data, e.data);
        chk("win_row", XW'(win_row), XW'(e.row));
        chk("win_col", XW'(win_col), XW'(e.col));
        chk("frame_done", XW'(frame_done), XW'(e.fd));
        if (e.m == 0 && e.row == 0 && e.col == 0)
          chk("ramp00_e24", XW'(win_data[24*DW +: DW]), XW'(132));
        if (e.m == 0 && e.row == 5 && e.col == 9)
          chk("ramp59_e12", XW'(win_data[12*DW +: DW]), XW'(235));
        if (e.m == 0 && e.row == 27 && e.col == 27) begin
          chk("last_e24", XW'(win_data[24*DW +: DW]), XW'(1023));
          chk("last_fd", XW'(frame_done), XW'(1));
        end
        if (e.m == 1 && e.row == 0 && e.col == 0) begin
          chk("neg00_e0", XW'(win_data[0 +: DW]), XW'(0));
          chk("neg00_e6", XW'(win_data[6*DW +: DW]), XW'(12'hFDF));
        end
      end
    end
    @(posedge clk);
    #1;
    up = 1'b1;
    if (cons) pend = 1'b0;
    if (acc) begin
      img[mr][mc] = px;
      if (mr >= 4 && mc >= 4) begin
        for (int k = 0; k < NT; k++) e.data[k*DW +: DW] = img[mr-4+k/5][mc-4+k%5];
        e.row = mr - 4;
        e.col = mc - 4;
        e.fd  = (mr == H - 1) && (mc == W - 1);
        e.m   = mode;
        q.push_back(e);
        pend = 1'b1;
      end
      acc_cnt++;
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  endtask

  task automatic run_frame(int m, int gap, int stall, int stop, bit drain);
    int budget;
    budget  = 0;
    mode    = m;
    acc_cnt = 0;
    while (acc_cnt < stop && budget < 20000) begin
      step($urandom_range(99) >= gap, $urandom_range(99) >= stall);
      budget++;
    end
    chk("frame_pixels", XW'(acc_cnt), XW'(stop));
    if (drain) begin
      budget = 0;
      while ((q.size() > 0 || pend) && budget < 500) begin
        step(1'b0, $urandom_range(99) >= stall);
        budget++;
      end
      chk("drained", XW'(q.size()), XW'(0));
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; win_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk("rst_in_ready", XW'(in_ready), XW'(0));
      chk("rst_win_valid", XW'(win_valid), XW'(0));
      chk("rst_win_data", win_data, XW'(0));
      chk("rst_win_rc", XW'({win_row, win_col}), XW'(0));
      chk("rst_frame_done", XW'(frame_done), XW'(0));
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
    q.delete();
    pend = 1'b0; up = 1'b0; mr = 0; mc = 0;
  endtask

  initial begin
    mode = 0; mr = 0; mc = 0; pend = 1'b0; up = 1'b0;
    #3;
    do_reset();

    win_cnt = 0;
    run_frame(0, 0, 0, W * H, 1);
    chk("ramp_windows", XW'(win_cnt), XW'(784));

    win_cnt = 0;
    run_frame(0, 0, 35, W * H, 1);
    chk("stall_windows", XW'(win_cnt), XW'(784));

    win_cnt = 0;
    run_frame(0, 35, 0, W * H, 1);
    chk("gap_windows", XW'(win_cnt), XW'(784));

    win_cnt = 0;
    run_frame(0, 0, 0, W * H, 0);
    run_frame(1, 15, 15, W * H, 1);
    chk("b2b_windows", XW'(win_cnt), XW'(1568));

    run_frame(0, 10, 10, 10 * W + 17, 0);
    do_reset();
    win_cnt = 0;
    run_frame(0, 0, 0, W * H, 1);
    chk("post_rst_windows", XW'(win_cnt), XW'(784));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
